timer_ctrl: RTL and testbench

TIMER_CTRL -- requirements
Module: timer_ctrl

---
 rtl/timer_ctrl.sv | 167 ++++++++++++++++
 tb/tb_timer_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl.sv
// timer_ctrl: APB-programmed control block for an external up/down counter.
// Provides start value, load handshake, enable/direction, a prescaled counter
// clock, sticky overflow/underflow status and a level interrupt.
// Optional feature macro: TIMER_CTRL_IRQ_EN (interrupt enables and irq output).
module timer_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  PCLK,
  input  logic                  PRESET_n,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [1:0]            PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic                  Clock_counter,
  output logic [DATA_WIDTH-1:0] count_start_value,
  output logic                  count_load,
  output logic                  count_enable,
  output logic                  count_up_down,
  input  logic [DATA_WIDTH-1:0] TCNT_In,
  input  logic                  Set_OVF_pulse,
  input  logic                  Set_UDF_pulse,
  output logic                  irq
);

  typedef enum logic {IDLE = 1'b0, LOAD_WAIT = 1'b1} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic                    wr_en;
  logic                    wr_tdr;
  logic                    wr_tcr;
  logic                    wr_tsr;
  logic                    load_req;
  logic [DATA_WIDTH-1:0]   tdr;
  logic                    en;
  logic                    up_dn;
  logic [1:0]              cks;
  logic                    ovfie;
  logic                    udfie;
  logic                    ovf;
  logic                    udf;
  logic [3:0]              div_cnt;
  logic                    clock_counter_p1;
  logic                    cc_rise;
  logic [7:0]              tcr_rd;
  logic                    unused_pwdata;

  assign wr_en    = PSEL & PENABLE & PWRITE;
  assign wr_tdr   = wr_en & (PADDR == 2'd0);
  assign wr_tcr   = wr_en & (PADDR == 2'd1);
  assign wr_tsr   = wr_en & (PADDR == 2'd2);
  assign load_req = wr_tcr & PWDATA[7];
  assign cc_rise  = Clock_counter & ~clock_counter_p1;

  // Bit 6 and bits above 7 of PWDATA carry no register field.
  assign unused_pwdata = ^PWDATA;

  assign PREADY            = 1'b1;
  assign PSLVERR           = 1'b0;
  assign count_start_value = tdr;
  assign count_enable      = en;
  assign count_up_down     = up_dn;

  // TDR and the stored TCR fields; LOAD is not stored, it reflects the FSM.
  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      tdr   <= '0;
      en    <= 1'b0;
      up_dn <= 1'b0;
      cks   <= 2'd0;
    end else begin
      if (wr_tdr) tdr <= PWDATA;
      if (wr_tcr) begin
        en    <= PWDATA[4];
        up_dn <= PWDATA[5];
        cks   <= PWDATA[1:0];
      end
    end
  end

`ifdef TIMER_CTRL_IRQ_EN
  // Interrupt enables and the registered interrupt level.
  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      ovfie <= 1'b0;
      udfie <= 1'b0;
      irq   <= 1'b0;
    end else begin
      if (wr_tcr) begin
        ovfie <= PWDATA[2];
        udfie <= PWDATA[3];
      end
      irq <= (ovf & ovfie) | (udf & udfie);
    end
  end
`else
  assign ovfie = 1'b0;
  assign udfie = 1'b0;
  assign irq   = 1'b0;
`endif

  // Sticky status flags; a hardware set beats a same-cycle write-1-to-clear.
  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      ovf <= Set_OVF_pulse | (ovf & ~(wr_tsr & PWDATA[0]));
      udf <= Set_UDF_pulse | (udf & ~(wr_tsr & PWDATA[1]));
    end
  end

  // Free-running prescaler; the selected divider bit becomes the counter clock.
  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      div_cnt          <= 4'd0;
      Clock_counter    <= 1'b0;
      clock_counter_p1 <= 1'b0;
    end else begin
      div_cnt          <= div_cnt + 4'd1;
      Clock_counter    <= div_cnt[cks];
      clock_counter_p1 <= Clock_counter;
    end
  end

  // Load FSM state register.
  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) state <= IDLE;
    else           state <= state_nxt;
  end

  // Load FSM: hold count_load until the counter has seen one rising clock edge.
  always_comb begin
    state_nxt  = state;
    count_load = 1'b0;
    case (state)
      IDLE: begin
        if (load_req) state_nxt = LOAD_WAIT;
      end
      LOAD_WAIT: begin
        count_load = 1'b1;
        if (!load_req && cc_rise) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign tcr_rd = {(state == LOAD_WAIT), 1'b0, up_dn, en, udfie, ovfie, cks};

  // Combinational read mux; forced to zero outside a selected, out-of-reset access.
  always_comb begin
    PRDATA = '0;
    if (PSEL && PRESET_n) begin
      case (PADDR)
        2'd0:    PRDATA = tdr;
        2'd1:    PRDATA = DATA_WIDTH'(tcr_rd);
        2'd2:    PRDATA = DATA_WIDTH'({udf, ovf});
        default: PRDATA = TCNT_In;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl: directed scenarios with literal
// expectations plus a randomized run compared every cycle against a model.
module tb_timer_ctrl;
  localparam int DW = 8;
`ifdef TIMER_CTRL_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic          PCLK = 1'b0;
  logic          PRESET_n = 1'b0;
  logic          PSEL = 1'b0;
  logic          PENABLE = 1'b0;
  logic          PWRITE = 1'b0;
  logic [1:0]    PADDR = 2'd0;
  logic [DW-1:0] PWDATA = '0;
  logic [DW-1:0] TCNT_In = '0;
  logic          Set_OVF_pulse = 1'b0;
  logic          Set_UDF_pulse = 1'b0;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;
  logic          Clock_counter;
  logic [DW-1:0] count_start_value;
  logic          count_load;
  logic          count_enable;
  logic          count_up_down;
  logic          irq;

  timer_ctrl #(.DATA_WIDTH(DW)) dut (
    .PCLK(PCLK), .PRESET_n(PRESET_n),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .Clock_counter(Clock_counter), .count_start_value(count_start_value),
    .count_load(count_load), .count_enable(count_enable),
    .count_up_down(count_up_down), .TCNT_In(TCNT_In),
    .Set_OVF_pulse(Set_OVF_pulse), .Set_UDF_pulse(Set_UDF_pulse), .irq(irq)
  );

  always #5 PCLK = ~PCLK;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: cycle count since reset stands in for the prescaler,
  // register fields are kept as plain variables.
  int         m_cyc = 0;
  bit         m_cc = 0, m_ccp = 0, m_load = 0, m_en = 0, m_ud = 0;
  bit         m_oie = 0, m_uie = 0, m_ovf = 0, m_udf = 0, m_irq = 0;
  logic [1:0] m_cks = 2'd0;
  logic [7:0] m_tdr = 8'd0;
  bit         t_wr, t_cc, t_rise;

  initial forever begin
    @(posedge PCLK or negedge PRESET_n);
    if (!PRESET_n) begin
      m_cyc = 0; m_cc = 0; m_ccp = 0; m_load = 0; m_en = 0; m_ud = 0;
      m_oie = 0; m_uie = 0; m_ovf = 0; m_udf = 0; m_irq = 0;
      m_cks = 2'd0; m_tdr = 8'd0;
    end else begin
      t_wr   = PSEL && PENABLE && PWRITE;
      t_cc   = ((((m_cyc % 16) >> m_cks) % 2) == 1);
      t_rise = m_cc && !m_ccp;
      m_load = (t_wr && PADDR == 2'd1 && PWDATA[7]) || (m_load && !t_rise);
      m_irq  = IRQ_ON && ((m_ovf && m_oie) || (m_udf && m_uie));
      m_ovf  = Set_OVF_pulse || (m_ovf && !(t_wr && PADDR == 2'd2 && PWDATA[0]));
      m_udf  = Set_UDF_pulse || (m_udf && !(t_wr && PADDR == 2'd2 && PWDATA[1]));
      if (t_wr && PADDR == 2'd0) m_tdr = PWDATA;
      if (t_wr && PADDR == 2'd1) begin
        m_en  = PWDATA[4];
        m_ud  = PWDATA[5];
        m_cks = PWDATA[1:0];
        m_oie = IRQ_ON && PWDATA[2];
        m_uie = IRQ_ON && PWDATA[3];
      end
      m_ccp = m_cc;
      m_cc  = t_cc;
      m_cyc = m_cyc + 1;
    end
  end

  function automatic logic [7:0] exp_rd();
    if (!PRESET_n || !PSEL) return 8'd0;
    case (PADDR)
      2'd0:    return m_tdr;
      2'd1:    return {m_load, 1'b0, m_ud, m_en, m_uie, m_oie, m_cks};
      2'd2:    return {6'd0, m_udf, m_ovf};
      default: return TCNT_In;
    endcase
  endfunction

  // Per-cycle comparison of every output against the model.
  initial forever begin
    @(negedge PCLK);
    if (chk_on) begin
      chk("Clock_counter", 32'(Clock_counter), 32'(m_cc));
      chk("count_load", 32'(count_load), 32'(m_load));
      chk("count_start_value", 32'(count_start_value), 32'(m_tdr));
      chk("count_enable", 32'(count_enable), 32'(m_en));
      chk("count_up_down", 32'(count_up_down), 32'(m_ud));
      chk("irq", 32'(irq), 32'(m_irq));
      chk("PRDATA", 32'(PRDATA), 32'(exp_rd()));
      chk("PREADY", 32'(PREADY), 32'd1);
      chk("PSLVERR", 32'(PSLVERR), 32'd0);
    end
  end

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic apb_write(input logic [1:0] a, input logic [7:0] d);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    step();
    PENABLE = 1'b1;
    step();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [1:0] a, output logic [7:0] d);
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = a;
    @(negedge PCLK);
    d = PRDATA;
    step();
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    int hi, lo, guard, n;

    // Reset state
    repeat (2) @(posedge PCLK);
    #1 chk_on = 1'b1;
    @(negedge PCLK);
    chk("rst_count_load", 32'(count_load), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_Clock_counter", 32'(Clock_counter), 32'd0);
    chk("rst_start_value", 32'(count_start_value), 32'd0);
    step();
    PRESET_n = 1'b1;
    step();

    // Bus checks: TCNT mirror, write to address 3 ignored
    TCNT_In = 8'h3C;
    apb_read(2'd3, rd);
    chk("tcnt_read", 32'(rd), 32'h3C);
    apb_write(2'd0, 8'h5A);
    apb_write(2'd1, 8'h21);
    apb_write(2'd3, 8'hFF);
    apb_read(2'd0, rd);
    chk("tdr_after_a3_write", 32'(rd), 32'h5A);
    apb_read(2'd1, rd);
    chk("tcr_after_a3_write", 32'(rd), 32'h21);
    apb_read(2'd2, rd);
    chk("tsr_after_a3_write", 32'(rd), 32'h00);

    // Prescaler period and duty for every CKS
    for (int k = 0; k < 4; k++) begin
      apb_write(2'd1, 8'(k));
      repeat (40) step();
      guard = 0;
      while (Clock_counter !== 1'b0 && guard < 100) begin @(negedge PCLK); guard++; end
      while (Clock_counter !== 1'b1 && guard < 200) begin @(negedge PCLK); guard++; end
      hi = 0;
      while (Clock_counter === 1'b1 && hi < 100) begin @(negedge PCLK); hi++; end
      lo = 0;
      while (Clock_counter === 1'b0 && lo < 100) begin @(negedge PCLK); lo++; end
      chk($sformatf("cks%0d_high", k), 32'(hi), 32'(1 << k));
      chk($sformatf("cks%0d_low", k), 32'(lo), 32'(1 << k));
      step();
    end

    // Load handshake with CKS=2
    apb_write(2'd0, 8'hA5);
    apb_write(2'd1, 8'h82);
    @(negedge PCLK);
    chk("load_asserted", 32'(count_load), 32'd1);
    chk("load_start_value", 32'(count_start_value), 32'hA5);
    n = 0;
    while (count_load === 1'b1 && n < 40) begin @(negedge PCLK); n++; end
    chk("load_released", 32'(count_load), 32'd0);
    chk("load_release_cc_high", 32'(Clock_counter), 32'd1);
    chk("load_len_ok", 32'(n >= 1 && n <= 9), 32'd1);
    step();
    apb_read(2'd1, rd);
    chk("tcr_after_load", 32'(rd), 32'h02);

    // Overflow interrupt
    apb_write(2'd1, 8'h14);
    Set_OVF_pulse = 1'b1;
    step();
    Set_OVF_pulse = 1'b0;
    @(negedge PCLK);
    chk("irq_latency", 32'(irq), 32'd0);
    @(negedge PCLK);
    chk("irq_set", 32'(irq), 32'(IRQ_ON));
    step();
    apb_read(2'd2, rd);
    chk("tsr_ovf", 32'(rd), 32'h01);
    apb_write(2'd2, 8'h01);
    step();
    @(negedge PCLK);
    chk("irq_cleared", 32'(irq), 32'd0);
    step();
    apb_read(2'd2, rd);
    chk("tsr_after_w1c", 32'(rd), 32'h00);

    // Set/clear collision on UDF
    Set_UDF_pulse = 1'b1;
    step();
    Set_UDF_pulse = 1'b0;
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = 2'd2; PWDATA = 8'h02;
    step();
    PENABLE = 1'b1; Set_UDF_pulse = 1'b1;
    step();
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; Set_UDF_pulse = 1'b0;
    apb_read(2'd2, rd);
    chk("udf_set_wins", 32'(rd), 32'h02);
    apb_write(2'd2, 8'h02);
    apb_read(2'd2, rd);
    chk("udf_w1c", 32'(rd), 32'h00);

    // Reset in the middle of a pending load
    apb_write(2'd1, 8'h93);
    @(negedge PCLK);
    chk("mid_load_asserted", 32'(count_load), 32'd1);
    step();
    PSEL = 1'b1; PADDR = 2'd0;
    #2 PRESET_n = 1'b0;
    #1;
    chk("arst_count_load", 32'(count_load), 32'd0);
    chk("arst_count_enable", 32'(count_enable), 32'd0);
    chk("arst_start_value", 32'(count_start_value), 32'd0);
    chk("arst_Clock_counter", 32'(Clock_counter), 32'd0);
    chk("arst_irq", 32'(irq), 32'd0);
    chk("arst_PRDATA", 32'(PRDATA), 32'd0);
    PSEL = 1'b0;
    step();
    PRESET_n = 1'b1;
    step();
    @(negedge PCLK);
    chk("post_rst_start_value", 32'(count_start_value), 32'd0);
    chk("post_rst_enable", 32'(count_enable), 32'd0);
    chk("post_rst_load", 32'(count_load), 32'd0);
    step();

    // Randomized traffic, checked every cycle by the compare process
    repeat (3000) begin
      PSEL          = 1'($urandom_range(0, 1));
      PENABLE       = 1'($urandom_range(0, 1));
      PWRITE        = 1'($urandom_range(0, 1));
      PADDR         = 2'($urandom_range(0, 3));
      PWDATA        = 8'($urandom_range(0, 255));
      TCNT_In       = 8'($urandom_range(0, 255));
      Set_OVF_pulse = ($urandom_range(0, 9) == 0);
      Set_UDF_pulse = ($urandom_range(0, 9) == 0);
      PRESET_n      = ($urandom_range(0, 399) != 0);
      step();
    end
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    Set_OVF_pulse = 1'b0; Set_UDF_pulse = 1'b0; PRESET_n = 1'b1;
    repeat (4) step();

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
